// File: rtl/core_types_pkg.sv
// core_types_pkg -- types and widths shared across the core.
//   N_BITS   : default address / instruction width.
//   pc_sel_t : next-PC select. PC_PLUS4 means "no redirect"; the other
//              three values pick the jal, branch or jalr target.
package core_types_pkg;

   localparam int N_BITS = 32;

   typedef enum logic [1:0] {
      PC_PLUS4  = 2'd0,
      PC_JAL    = 2'd1,
      PC_BRANCH = 2'd2,
      PC_JALR   = 2'd3
   } pc_sel_t;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if -- instruction-memory and decode handshakes of the fetch unit.
//   imem_req_val/rdy/addr : fetch request channel (fetch unit -> memory)
//   imem_resp_val/data    : in-order response channel, always accepted
//   f_val/rdy/inst/pc/pc_plus4 : instruction channel to decode
// modport master = fetch unit side, modport slave = memory/decode side.
interface fetch_unit_if #(
   parameter int N_BITS = core_types_pkg::N_BITS
);
   logic              imem_req_val;
   logic              imem_req_rdy;
   logic [N_BITS-1:0] imem_req_addr;
   logic              imem_resp_val;
   logic [N_BITS-1:0] imem_resp_data;
   logic              f_val;
   logic              f_rdy;
   logic [N_BITS-1:0] f_inst;
   logic [N_BITS-1:0] f_pc;
   logic [N_BITS-1:0] f_pc_plus4;

   modport master (
      output imem_req_val, imem_req_addr,
      input  imem_req_rdy, imem_resp_val, imem_resp_data,
      output f_val, f_inst, f_pc, f_pc_plus4,
      input  f_rdy
   );

   modport slave (
      input  imem_req_val, imem_req_addr,
      output imem_req_rdy, imem_resp_val, imem_resp_data,
      input  f_val, f_inst, f_pc, f_pc_plus4,
      output f_rdy
   );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue -- in-order queue of fetched PCs awaiting their instruction word.
//   alloc/alloc_pc   : append an entry holding alloc_pc with an empty slot
//   fill/fill_data   : write the oldest unfilled entry's instruction
//   pop              : retire the head entry
//   flush            : drop every entry (wins over the other operations)
//   head_val/pc/inst : head entry, head_val set when it is filled
//   live_cnt, unfilled_cnt : occupancy
// Entries are filled in allocation order, so the filled entries always form a
// prefix starting at the head; one filled counter is enough to know the head
// is ready.
module fetch_queue #(
   parameter int FQ_DEPTH = 4,
   parameter int N_BITS   = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          alloc,
   input  logic [N_BITS-1:0]             alloc_pc,
   input  logic                          fill,
   input  logic [N_BITS-1:0]             fill_data,
   input  logic                          pop,
   input  logic                          flush,
   output logic                          head_val,
   output logic [N_BITS-1:0]             head_pc,
   output logic [N_BITS-1:0]             head_inst,
   output logic [$clog2(FQ_DEPTH+1)-1:0] live_cnt,
   output logic [$clog2(FQ_DEPTH+1)-1:0] unfilled_cnt
);
   localparam int PTR_W = $clog2(FQ_DEPTH);
   localparam int CNT_W = $clog2(FQ_DEPTH+1);

   logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d, fill_ptr_q, fill_ptr_d;
   logic [CNT_W-1:0]  live_q, live_d, filled_q, filled_d;
   logic [N_BITS-1:0] pc_mem_q [FQ_DEPTH];
   logic [N_BITS-1:0] pc_mem_d [FQ_DEPTH];
   logic [N_BITS-1:0] inst_mem_q [FQ_DEPTH];
   logic [N_BITS-1:0] inst_mem_d [FQ_DEPTH];

   // Next-state of pointers, counts and storage.
   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      fill_ptr_d = fill_ptr_q;
      live_d     = live_q;
      filled_d   = filled_q;
      pc_mem_d   = pc_mem_q;
      inst_mem_d = inst_mem_q;
      if (flush) begin
         head_d     = '0;
         tail_d     = '0;
         fill_ptr_d = '0;
         live_d     = '0;
         filled_d   = '0;
      end else begin
         if (alloc) begin
            pc_mem_d[tail_q] = alloc_pc;
            tail_d           = tail_q + PTR_W'(1);
         end else begin
            tail_d = tail_q;
         end
         if (fill) begin
            inst_mem_d[fill_ptr_q] = fill_data;
            fill_ptr_d             = fill_ptr_q + PTR_W'(1);
         end else begin
            fill_ptr_d = fill_ptr_q;
         end
         if (pop) begin
            head_d = head_q + PTR_W'(1);
         end else begin
            head_d = head_q;
         end
         live_d   = live_q + CNT_W'(alloc) - CNT_W'(pop);
         filled_d = filled_q + CNT_W'(fill) - CNT_W'(pop);
      end
   end

   // Queue state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q     <= '0;
         tail_q     <= '0;
         fill_ptr_q <= '0;
         live_q     <= '0;
         filled_q   <= '0;
         pc_mem_q   <= '{default: '0};
         inst_mem_q <= '{default: '0};
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         fill_ptr_q <= fill_ptr_d;
         live_q     <= live_d;
         filled_q   <= filled_d;
         pc_mem_q   <= pc_mem_d;
         inst_mem_q <= inst_mem_d;
      end
   end

   assign head_val     = (filled_q != '0);
   assign head_pc      = pc_mem_q[head_q];
   assign head_inst    = inst_mem_q[head_q];
   assign live_cnt     = live_q;
   assign unfilled_cnt = live_q - filled_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit -- PC generation, instruction-memory requests and fetch queue.
//   clk, rst_n            : clock, asynchronous active-low reset
//   redirect_sel          : pc_sel_t, non-zero loads the selected target
//   jal_tgt/branch_tgt/jalr_tgt : redirect targets
//   bus (fetch_unit_if.master) : imem request/response and decode channels
//   fetch_cnt             : instructions handed to decode (only when the
//                           FETCH_PERF_CNT_EN macro is defined)
// Requests in flight at a redirect cannot be cancelled at the memory, so
// their responses are counted in drop_cnt and discarded on arrival.
module fetch_unit #(
   parameter int                N_BITS       = core_types_pkg::N_BITS,
   parameter logic [N_BITS-1:0] RESET_VECTOR = '0,
   parameter int                FQ_DEPTH     = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  core_types_pkg::pc_sel_t redirect_sel,
   input  logic [N_BITS-1:0]      jal_tgt,
   input  logic [N_BITS-1:0]      branch_tgt,
   input  logic [N_BITS-1:0]      jalr_tgt,
   fetch_unit_if.master           bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]            fetch_cnt
`endif
);
   import core_types_pkg::*;

   localparam int CNT_W = $clog2(FQ_DEPTH+1);
   localparam int SUM_W = CNT_W + 1;

   logic [N_BITS-1:0] pc_q, pc_d, tgt_s;
   logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
   logic [CNT_W-1:0]  live_cnt_s, unfilled_cnt_s;
   logic [SUM_W-1:0]  drop_sum_s;
   logic              redirect_s, room_s, req_val_s, hs_s, fill_s, pop_s, f_val_s;
   logic              head_val_s;
   logic [N_BITS-1:0] head_pc_s, head_inst_s;

   assign redirect_s = (redirect_sel != PC_PLUS4);
   // Outstanding responses still to be dropped occupy capacity like live entries.
   assign room_s     = (SUM_W'(live_cnt_s) + SUM_W'(drop_cnt_q)) < SUM_W'(FQ_DEPTH);
   // rst_n gating keeps the request quiet while reset is held.
   assign req_val_s  = rst_n && !redirect_s && room_s;
   assign hs_s       = req_val_s && bus.imem_req_rdy;
   assign f_val_s    = head_val_s && !redirect_s;
   assign pop_s      = f_val_s && bus.f_rdy;
   // A response in a redirect cycle is stale even when drop_cnt is zero.
   assign fill_s     = bus.imem_resp_val && !redirect_s && (drop_cnt_q == '0);

   fetch_queue #(
      .FQ_DEPTH (FQ_DEPTH),
      .N_BITS   (N_BITS)
   ) u_queue (
      .clk          (clk),
      .rst_n        (rst_n),
      .alloc        (hs_s),
      .alloc_pc     (pc_q),
      .fill         (fill_s),
      .fill_data    (bus.imem_resp_data),
      .pop          (pop_s),
      .flush        (redirect_s),
      .head_val     (head_val_s),
      .head_pc      (head_pc_s),
      .head_inst    (head_inst_s),
      .live_cnt     (live_cnt_s),
      .unfilled_cnt (unfilled_cnt_s)
   );

   // Next PC and drop count.
   always_comb begin
      pc_d       = pc_q;
      drop_cnt_d = drop_cnt_q;
      drop_sum_s = '0;
      case (redirect_sel)
         PC_JAL:    tgt_s = jal_tgt;
         PC_BRANCH: tgt_s = branch_tgt;
         PC_JALR:   tgt_s = jalr_tgt;
         default:   tgt_s = pc_q;
      endcase
      if (redirect_s) begin
         pc_d = tgt_s;
         // Every unfilled entry still has a response coming; one arriving
         // now is consumed here and must not be counted again.
         drop_sum_s = SUM_W'(drop_cnt_q) + SUM_W'(unfilled_cnt_s);
         if (bus.imem_resp_val && (drop_sum_s != '0)) begin
            drop_sum_s = drop_sum_s - SUM_W'(1);
         end else begin
            drop_sum_s = drop_sum_s;
         end
         drop_cnt_d = CNT_W'(drop_sum_s);
      end else begin
         if (hs_s) begin
            pc_d = pc_q + N_BITS'(32'd4);
         end else begin
            pc_d = pc_q;
         end
         if (bus.imem_resp_val && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CNT_W'(1);
         end else begin
            drop_cnt_d = drop_cnt_q;
         end
      end
   end

   // PC and drop counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_VECTOR;
         drop_cnt_q <= '0;
      end else begin
         pc_q       <= pc_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign bus.imem_req_val  = req_val_s;
   assign bus.imem_req_addr = pc_q;
   assign bus.f_val         = f_val_s;
   assign bus.f_inst        = head_inst_s;
   assign bus.f_pc          = head_pc_s;
   assign bus.f_pc_plus4    = head_pc_s + N_BITS'(32'd4);

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;

   // Count instructions delivered to decode; wraps naturally.
   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      if (pop_s) begin
         fetch_cnt_d = fetch_cnt_q + 32'd1;
      end else begin
         fetch_cnt_d = fetch_cnt_q;
      end
   end

   // Performance counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q <= 32'd0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   assign fetch_cnt = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
   import core_types_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   pc_sel_t     sel;
   logic [31:0] jal_t, br_t, jalr_t;

   fetch_unit_if #(.N_BITS(32)) bus ();
   fetch_unit_if #(.N_BITS(32)) bus2 ();

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt, fetch_cnt2;
`endif

   fetch_unit #(.N_BITS(32), .RESET_VECTOR(32'h0000_0000), .FQ_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .redirect_sel(sel),
      .jal_tgt(jal_t), .branch_tgt(br_t), .jalr_tgt(jalr_t), .bus(bus)
`ifdef FETCH_PERF_CNT_EN
      , .fetch_cnt(fetch_cnt)
`endif
   );

   // Second instance: only the wrapping reset vector is observed here.
   fetch_unit #(.N_BITS(32), .RESET_VECTOR(32'hFFFF_FFFC), .FQ_DEPTH(4)) dut2 (
      .clk(clk), .rst_n(rst_n), .redirect_sel(PC_PLUS4),
      .jal_tgt(32'h0), .branch_tgt(32'h0), .jalr_tgt(32'h0), .bus(bus2)
`ifdef FETCH_PERF_CNT_EN
      , .fetch_cnt(fetch_cnt2)
`endif
   );

   // ---------------- behavioural model ----------------
   logic [31:0] m_pc;
   logic [31:0] live_q[$];   // PCs the decoder is still owed, oldest first
   int          nfill;       // how many of those (from the front) have data
   int          drop;        // responses still owed for flushed requests
   logic [31:0] pend[$];     // memory: accepted addresses awaiting a response
   logic [31:0] hs_log[$], pop_log[$], hs2_log[$];
   int vectors = 0, miscompares = 0;

   function automatic logic [31:0] word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hC3C3_5A5A;
   endfunction

   function automatic logic exp_req_val();
      return rst_n && (sel == PC_PLUS4) && ((live_q.size() + drop) < 4);
   endfunction

   function automatic logic exp_f_val();
      return rst_n && (nfill > 0) && (sel == PC_PLUS4);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_log(input string nm, input logic [31:0] q[$], input int idx,
                          input logic [31:0] exp);
      if (idx >= q.size()) begin
         vectors++;
         miscompares++;
         $display("FAIL %s: entry %0d missing, want %h", nm, idx, exp);
      end else begin
         chk(nm, q[idx], exp);
      end
   endtask

   task automatic model_clear();
      m_pc = 32'h0000_0000;
      live_q.delete();
      pend.delete();
      nfill = 0;
      drop  = 0;
   endtask

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin
      chk("req_val", 32'(bus.imem_req_val), 32'(exp_req_val()));
      if (exp_req_val()) chk("req_addr", bus.imem_req_addr, m_pc);
      chk("f_val", 32'(bus.f_val), 32'(exp_f_val()));
      if (exp_f_val()) begin
         chk("f_pc", bus.f_pc, live_q[0]);
         chk("f_inst", bus.f_inst, word(live_q[0]));
         chk("f_pc_plus4", bus.f_pc_plus4, live_q[0] + 32'd4);
      end
      if (bus.imem_req_val && bus.imem_req_rdy) hs_log.push_back(bus.imem_req_addr);
      if (bus.f_val && bus.f_rdy) pop_log.push_back(bus.f_pc);
      if (bus2.imem_req_val && bus2.imem_req_rdy) hs2_log.push_back(bus2.imem_req_addr);
   end

   // Apply one cycle's inputs; the memory answers from its pending list.
   task automatic drive(input logic rdy, input logic frdy, input logic ren,
                        input pc_sel_t s, input logic [31:0] tgt);
      bus.imem_req_rdy = rdy;
      bus.f_rdy        = frdy;
      sel              = s;
      jal_t  = 32'h0000_1110;
      br_t   = 32'h0000_2220;
      jalr_t = 32'h0000_3330;
      case (s)
         PC_JAL:    jal_t  = tgt;
         PC_BRANCH: br_t   = tgt;
         PC_JALR:   jalr_t = tgt;
         default:   ;
      endcase
      if (rst_n && ren && pend.size() > 0) begin
         bus.imem_resp_val  = 1'b1;
         bus.imem_resp_data = word(pend[0]);
      end else begin
         bus.imem_resp_val  = 1'b0;
         bus.imem_resp_data = 32'hDEAD_BEEF;
      end
   endtask

   // Advance the model across one clock edge.
   task automatic adv();
      logic        hs, pp, rs;
      logic [31:0] tgt;
      int          d;
      hs = exp_req_val() && bus.imem_req_rdy;
      pp = exp_f_val() && bus.f_rdy;
      rs = bus.imem_resp_val;
      tgt = (sel == PC_JAL) ? jal_t : (sel == PC_BRANCH) ? br_t : jalr_t;
      @(posedge clk);
      if (rst_n) begin
         if (sel != PC_PLUS4) begin
            d = drop + (live_q.size() - nfill) - (rs ? 1 : 0);
            drop = (d < 0) ? 0 : d;
            live_q.delete();
            nfill = 0;
            m_pc  = tgt;
         end else begin
            if (rs) begin
               if (drop > 0) drop--;
               else nfill++;
            end
            if (pp) begin
               void'(live_q.pop_front());
               nfill--;
            end
            if (hs) live_q.push_back(m_pc);
         end
         if (rs) void'(pend.pop_front());
         if (hs) begin
            pend.push_back(m_pc);
            m_pc = m_pc + 32'd4;
         end
      end
      #1;
   endtask

   task automatic cyc(input logic rdy, input logic frdy, input logic ren,
                      input pc_sel_t s, input logic [31:0] tgt);
      drive(rdy, frdy, ren, s, tgt);
      adv();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.imem_resp_val = 1'b0;
      sel = PC_PLUS4;
      model_clear();
      @(negedge clk);
      chk("rst_req_val", 32'(bus.imem_req_val), 32'd0);
      chk("rst_f_val", 32'(bus.f_val), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   int m, p;

   initial begin
      bus.imem_req_rdy   = 1'b1;
      bus.f_rdy          = 1'b1;
      bus.imem_resp_val  = 1'b0;
      bus.imem_resp_data = 32'h0;
      bus2.imem_req_rdy   = 1'b1;
      bus2.f_rdy          = 1'b0;
      bus2.imem_resp_val  = 1'b0;
      bus2.imem_resp_data = 32'h0;
      jal_t = 32'h0; br_t = 32'h0; jalr_t = 32'h0;

      // Reset fetch: addresses and decode PCs 0, 4, 8.
      do_reset();
      m = hs_log.size(); p = pop_log.size();
      repeat (6) cyc(1'b1, 1'b1, 1'b1, PC_PLUS4, 32'h0);
      chk_log("rf_addr0", hs_log, m,     32'h0);
      chk_log("rf_addr1", hs_log, m + 1, 32'h4);
      chk_log("rf_addr2", hs_log, m + 2, 32'h8);
      chk_log("rf_pc0", pop_log, p,     32'h0);
      chk_log("rf_pc1", pop_log, p + 1, 32'h4);
      chk_log("rf_pc2", pop_log, p + 2, 32'h8);

      // Backpressure: queue full after 4 requests, one pop re-opens it.
      do_reset();
      m = hs_log.size();
      repeat (8) cyc(1'b1, 1'b0, 1'b1, PC_PLUS4, 32'h0);
      chk("bp_hs_cnt", 32'(hs_log.size() - m), 32'd4);
      chk("bp_req_off", 32'(bus.imem_req_val), 32'd0);
      chk("bp_f_pc", bus.f_pc, 32'h0);
      cyc(1'b1, 1'b1, 1'b1, PC_PLUS4, 32'h0);
      chk("bp_req_on", 32'(bus.imem_req_val), 32'd1);
      chk("bp_f_pc_next", bus.f_pc, 32'h4);
      repeat (3) cyc(1'b1, 1'b0, 1'b1, PC_PLUS4, 32'h0);

      // Redirect with two requests in flight.
      do_reset();
      repeat (2) cyc(1'b1, 1'b1, 1'b0, PC_PLUS4, 32'h0);
      m = hs_log.size(); p = pop_log.size();
      cyc(1'b0, 1'b1, 1'b0, PC_JALR, 32'h0000_0100);
      chk("jalr_addr", bus.imem_req_addr, 32'h0000_0100);
      repeat (8) cyc(1'b1, 1'b1, 1'b1, PC_PLUS4, 32'h0);
      chk_log("jalr_hs0", hs_log, m, 32'h0000_0100);
      chk_log("jalr_pop0", pop_log, p, 32'h0000_0100);

      // Branch redirect colliding with a response and f_rdy.
      do_reset();
      repeat (4) cyc(1'b1, 1'b1, 1'b1, PC_PLUS4, 32'h0);
      m = hs_log.size(); p = pop_log.size();
      drive(1'b1, 1'b1, 1'b1, PC_BRANCH, 32'h0000_0040);
      #2;
      chk("br_resp_present", 32'(bus.imem_resp_val), 32'd1);
      chk("br_f_val", 32'(bus.f_val), 32'd0);
      adv();
      repeat (5) cyc(1'b1, 1'b1, 1'b1, PC_PLUS4, 32'h0);
      chk_log("br_hs0", hs_log, m, 32'h0000_0040);
      chk_log("br_pop0", pop_log, p, 32'h0000_0040);

      // Mid-stream asynchronous reset.
      do_reset();
      repeat (5) cyc(1'b1, 1'b1, 1'b1, PC_PLUS4, 32'h0);
      drive(1'b1, 1'b1, 1'b1, PC_PLUS4, 32'h0);
      #2;
      chk("pre_rst_f_val", 32'(bus.f_val), 32'd1);
      rst_n = 1'b0;
      model_clear();
      bus.imem_resp_val = 1'b0;
      #1;
      chk("midrst_f_val", 32'(bus.f_val), 32'd0);
      chk("midrst_req_val", 32'(bus.imem_req_val), 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      m = hs_log.size(); p = pop_log.size();
      repeat (4) cyc(1'b1, 1'b1, 1'b1, PC_PLUS4, 32'h0);
      chk_log("rst_hs0", hs_log, m, 32'h0);
      chk_log("rst_pop0", pop_log, p, 32'h0);

`ifdef FETCH_PERF_CNT_EN
      // Performance counter: 5 pops, then wrap from all-ones.
      do_reset();
      repeat (7) cyc(1'b1, 1'b1, 1'b1, PC_PLUS4, 32'h0);
      chk("perf_cnt5", fetch_cnt, 32'd5);
      drive(1'b1, 1'b0, 1'b1, PC_PLUS4, 32'h0);
      force dut.fetch_cnt_q = 32'hFFFF_FFFF;
      adv();
      release dut.fetch_cnt_q;
      cyc(1'b1, 1'b1, 1'b1, PC_PLUS4, 32'h0);
      chk("perf_wrap", fetch_cnt, 32'd0);
`endif

      // Wrapping reset vector on the second instance.
      chk_log("wrap_addr0", hs2_log, 0, 32'hFFFF_FFFC);
      chk_log("wrap_addr1", hs2_log, 1, 32'h0000_0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
